// File: rtl/pe_tile_sequencer.sv
// Tile-level sequencer for one PE group: weight preload, concurrent input/partial-sum
// streaming and result write counting per tile. Optional counters under PE_SEQ_PERF_EN.
module pe_tile_sequencer #(
  parameter int unsigned          AddrWidth      = 16,
  parameter int unsigned          TileCountWidth = 8,
  parameter int unsigned          W_Words        = 16,
  parameter int unsigned          I_Words        = 19,
  parameter int unsigned          O_In_Words     = 4,
  parameter int unsigned          O_Out_Words    = 4,
  parameter logic [AddrWidth-1:0] W_Base         = '0,
  parameter logic [AddrWidth-1:0] I_Base         = '0,
  parameter logic [AddrWidth-1:0] O_Base         = '0
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      start,
  input  logic [TileCountWidth-1:0] num_tiles,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [TileCountWidth-1:0] tile_idx,
  output logic                      w_addr_valid,
  input  logic                      w_addr_rdy,
  output logic [AddrWidth-1:0]      w_addr,
  output logic                      i_addr_valid,
  input  logic                      i_addr_rdy,
  output logic [AddrWidth-1:0]      i_addr,
  output logic                      o_addr_valid,
  input  logic                      o_addr_rdy,
  output logic [AddrWidth-1:0]      o_addr,
`ifdef PE_SEQ_PERF_EN
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_stall,
`endif
  input  logic                      o_wr_fire,
  output logic [AddrWidth-1:0]      o_wr_addr
);

  localparam int unsigned WCntW  = $clog2(W_Words + 1);
  localparam int unsigned ICntW  = $clog2(I_Words + 1);
  localparam int unsigned OCntW  = $clog2(O_In_Words + 1);
  localparam int unsigned WrCntW = $clog2(O_Out_Words + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    FIN    = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TileCountWidth-1:0] tile_idx_q, tile_idx_d, num_tiles_q, num_tiles_d;
  logic                      w_valid_q, w_valid_d, i_valid_q, i_valid_d, o_valid_q, o_valid_d;
  logic [AddrWidth-1:0]      w_ptr_q, w_ptr_d, i_ptr_q, i_ptr_d;
  logic [AddrWidth-1:0]      o_ptr_q, o_ptr_d, o_wr_ptr_q, o_wr_ptr_d;
  logic [WCntW-1:0]          w_cnt_q, w_cnt_d;
  logic [ICntW-1:0]          i_cnt_q, i_cnt_d;
  logic [OCntW-1:0]          o_cnt_q, o_cnt_d;
  logic [WrCntW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                      tile_complete;

  assign tile_complete = (i_cnt_q == ICntW'(I_Words)) && (o_cnt_q == OCntW'(O_In_Words)) &&
                         (wr_cnt_q == WrCntW'(O_Out_Words));

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    w_valid_d   = w_valid_q;
    i_valid_d   = i_valid_q;
    o_valid_d   = o_valid_q;
    w_ptr_d     = w_ptr_q;
    i_ptr_d     = i_ptr_q;
    o_ptr_d     = o_ptr_q;
    o_wr_ptr_d  = o_wr_ptr_q;
    w_cnt_d     = w_cnt_q;
    i_cnt_d     = i_cnt_q;
    o_cnt_d     = o_cnt_q;
    wr_cnt_d    = wr_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_tiles != '0) begin
            state_d     = LOAD_W;
            busy_d      = 1'b1;
            w_valid_d   = 1'b1;
            num_tiles_d = num_tiles;
            tile_idx_d  = '0;
            w_ptr_d     = W_Base;
            i_ptr_d     = I_Base;
            o_ptr_d     = O_Base;
            o_wr_ptr_d  = O_Base;
            w_cnt_d     = '0;
            i_cnt_d     = '0;
            o_cnt_d     = '0;
            wr_cnt_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (w_valid_q && w_addr_rdy) begin
          w_ptr_d = w_ptr_q + AddrWidth'(1);
          w_cnt_d = w_cnt_q + WCntW'(1);
          if (w_cnt_q == WCntW'(W_Words - 1)) begin
            w_valid_d = 1'b0;
            i_valid_d = 1'b1;
            o_valid_d = 1'b1;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        if (i_valid_q && i_addr_rdy) begin
          i_ptr_d = i_ptr_q + AddrWidth'(1);
          i_cnt_d = i_cnt_q + ICntW'(1);
          if (i_cnt_q == ICntW'(I_Words - 1)) i_valid_d = 1'b0;
        end
        if (o_valid_q && o_addr_rdy) begin
          o_ptr_d = o_ptr_q + AddrWidth'(1);
          o_cnt_d = o_cnt_q + OCntW'(1);
          if (o_cnt_q == OCntW'(O_In_Words - 1)) o_valid_d = 1'b0;
        end
        // A surplus result write is flagged and dropped
        if (o_wr_fire) begin
          if (wr_cnt_q == WrCntW'(O_Out_Words)) begin
            err_d = 1'b1;
          end else begin
            o_wr_ptr_d = o_wr_ptr_q + AddrWidth'(1);
            wr_cnt_d   = wr_cnt_q + WrCntW'(1);
          end
        end
        if (tile_complete) begin
          if (tile_idx_q == num_tiles_q - TileCountWidth'(1)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d    = LOAD_W;
            tile_idx_d = tile_idx_q + TileCountWidth'(1);
            w_valid_d  = 1'b1;
            w_cnt_d    = '0;
            i_cnt_d    = '0;
            o_cnt_d    = '0;
            wr_cnt_d   = '0;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (o_wr_fire && (state_q != STREAM)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tile_idx_q  <= '0;
      num_tiles_q <= '0;
      w_valid_q   <= 1'b0;
      i_valid_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      w_ptr_q     <= W_Base;
      i_ptr_q     <= I_Base;
      o_ptr_q     <= O_Base;
      o_wr_ptr_q  <= O_Base;
      w_cnt_q     <= '0;
      i_cnt_q     <= '0;
      o_cnt_q     <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tile_idx_q  <= tile_idx_d;
      num_tiles_q <= num_tiles_d;
      w_valid_q   <= w_valid_d;
      i_valid_q   <= i_valid_d;
      o_valid_q   <= o_valid_d;
      w_ptr_q     <= w_ptr_d;
      i_ptr_q     <= i_ptr_d;
      o_ptr_q     <= o_ptr_d;
      o_wr_ptr_q  <= o_wr_ptr_d;
      w_cnt_q     <= w_cnt_d;
      i_cnt_q     <= i_cnt_d;
      o_cnt_q     <= o_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tile_idx     = tile_idx_q;
  assign w_addr_valid = w_valid_q;
  assign i_addr_valid = i_valid_q;
  assign o_addr_valid = o_valid_q;
  assign w_addr       = w_ptr_q;
  assign i_addr       = i_ptr_q;
  assign o_addr       = o_ptr_q;
  assign o_wr_addr    = o_wr_ptr_q;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stall_q, perf_stall_d;
  logic        stall_c;

  assign stall_c = (w_valid_q && !w_addr_rdy) || (i_valid_q && !i_addr_rdy) ||
                   (o_valid_q && !o_addr_rdy);

  // Saturating busy/stall counters, cleared by a start accepted in IDLE
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
    if (stall_c && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if ((state_q == IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Directed self-checking bench for pe_tile_sequencer; expected addresses come from a
// per-stream pointer model kept by the bench. Perf checks active under PE_SEQ_PERF_EN.
module tb_pe_tile_sequencer;

  logic        clk = 1'b0;
  logic        aclr, start, o_wr_fire;
  logic [7:0]  num_tiles, tile_idx;
  logic        busy, done, err;
  logic        w_addr_valid, w_addr_rdy, i_addr_valid, i_addr_rdy, o_addr_valid, o_addr_rdy;
  logic [15:0] w_addr, i_addr, o_addr, o_wr_addr;
`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_tile_sequencer dut (
    .clk          (clk),
    .aclr         (aclr),
    .start        (start),
    .num_tiles    (num_tiles),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .tile_idx     (tile_idx),
    .w_addr_valid (w_addr_valid),
    .w_addr_rdy   (w_addr_rdy),
    .w_addr       (w_addr),
    .i_addr_valid (i_addr_valid),
    .i_addr_rdy   (i_addr_rdy),
    .i_addr       (i_addr),
    .o_addr_valid (o_addr_valid),
    .o_addr_rdy   (o_addr_rdy),
    .o_addr       (o_addr),
`ifdef PE_SEQ_PERF_EN
    .perf_cycles  (perf_cycles),
    .perf_stall   (perf_stall),
`endif
    .o_wr_fire    (o_wr_fire),
    .o_wr_addr    (o_wr_addr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE, checking every address against the bench pointer model
  task automatic run_job(input int nt, input bit bp, input bit err_mode, input bit stall_w,
                         input bit busy_start);
    int          wc, ic, oc, fc, tiles, cyc_done;
    logic [15:0] we, ie, oe, fe;
    bit          got_done, fifth, fire, norm_fire, tile_exit;
    wc = 0; ic = 0; oc = 0; fc = 0; tiles = 0; cyc_done = 0;
    we = 16'd0; ie = 16'd0; oe = 16'd0; fe = 16'd0;
    got_done = 1'b0; fifth = 1'b0;
    start = 1'b1; num_tiles = 8'(nt);
    step();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_err_clr", 32'(err), 32'd0);
    check_eq("start_tile", 32'(tile_idx), 32'd0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) step();
      start = busy_start && (cyc == 10);
      if (done) begin
        got_done = 1'b1;
        cyc_done = cyc;
        check_eq("done_tiles", 32'(tiles), 32'(nt));
        check_eq("fin_busy", 32'(busy), 32'd1);
        break;
      end
      tile_exit = (wc == 16) && (ic == 19) && (oc == 4) && (fc == 4);
      w_addr_rdy = (stall_w && cyc < 5) ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      i_addr_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      o_addr_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      norm_fire = !tile_exit && (wc == 16) && (fc < 4);
      fire = norm_fire;
      if (err_mode && tile_exit && !fifth) begin
        fire = 1'b1;
        fifth = 1'b1;
      end
      if (err_mode && cyc == 0) fire = 1'b1;
      o_wr_fire = fire;
      check_eq("w_valid", 32'(w_addr_valid), 32'(!tile_exit && wc < 16));
      check_eq("i_valid", 32'(i_addr_valid), 32'(!tile_exit && wc == 16 && ic < 19));
      check_eq("o_valid", 32'(o_addr_valid), 32'(!tile_exit && wc == 16 && oc < 4));
      check_eq("tile_idx", 32'(tile_idx), 32'(tiles));
      check_eq("busy", 32'(busy), 32'd1);
      if (w_addr_valid) check_eq("w_addr", 32'(w_addr), 32'(we));
      if (i_addr_valid) check_eq("i_addr", 32'(i_addr), 32'(ie));
      if (o_addr_valid) check_eq("o_addr", 32'(o_addr), 32'(oe));
      if (w_addr_valid && w_addr_rdy) begin we++; wc++; end
      if (i_addr_valid && i_addr_rdy) begin ie++; ic++; end
      if (o_addr_valid && o_addr_rdy) begin oe++; oc++; end
      if (norm_fire) begin
        check_eq("o_wr_addr", 32'(o_wr_addr), 32'(fe));
        fe++; fc++;
      end
`ifdef PE_SEQ_PERF_EN
      if (stall_w && cyc == 5) begin
        check_eq("perf_stall5", perf_stall, 32'd5);
        check_eq("perf_cyc5", perf_cycles, 32'd5);
      end
`endif
      if (tile_exit) begin
        tiles++;
        wc = 0; ic = 0; oc = 0; fc = 0;
      end
    end
    start = 1'b0; o_wr_fire = 1'b0;
    w_addr_rdy = 1'b1; i_addr_rdy = 1'b1; o_addr_rdy = 1'b1;
    if (!got_done) check_eq("done_timeout", 32'd0, 32'd1);
    step();
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_w_ptr", 32'(w_addr), 32'(16 * nt));
    check_eq("post_i_ptr", 32'(i_addr), 32'(19 * nt));
    check_eq("post_o_ptr", 32'(o_addr), 32'(4 * nt));
    check_eq("post_wr_ptr", 32'(o_wr_addr), 32'(4 * nt));
    check_eq("post_err", 32'(err), 32'(err_mode));
`ifdef PE_SEQ_PERF_EN
    check_eq("perf_cycles", perf_cycles, 32'(cyc_done + 1));
    if (!bp) check_eq("perf_stall", perf_stall, stall_w ? 32'd5 : 32'd0);
`endif
    step();
    check_eq("done_once", 32'(done), 32'd0);
`ifdef PE_SEQ_PERF_EN
    check_eq("perf_hold", perf_cycles, 32'(cyc_done + 1));
`endif
  endtask

  initial begin
    aclr = 1'b1; start = 1'b0; num_tiles = 8'd0; o_wr_fire = 1'b0;
    w_addr_rdy = 1'b1; i_addr_rdy = 1'b1; o_addr_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 aclr = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_valids", 32'({w_addr_valid, i_addr_valid, o_addr_valid}), 32'd0);
    check_eq("rst_tile", 32'(tile_idx), 32'd0);
    check_eq("rst_ptrs", 32'(w_addr | i_addr | o_addr | o_wr_addr), 32'd0);
    step();

    run_job(1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(3, 1'b0, 1'b0, 1'b0, 1'b1);
    run_job(2, 1'b1, 1'b0, 1'b0, 1'b0);
    run_job(1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check_eq("err_sticky", 32'(err), 32'd1);

    // Zero-tile job: done pulse only, err cleared, busy never rises
    start = 1'b1; num_tiles = 8'd0;
    step();
    start = 1'b0;
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_busy", 32'(busy), 32'd0);
    check_eq("zero_err", 32'(err), 32'd0);
    step();
    check_eq("zero_done_end", 32'(done), 32'd0);
    check_eq("zero_busy_end", 32'(busy), 32'd0);

    // Reset in the middle of STREAM
    start = 1'b1; num_tiles = 8'd2;
    step();
    start = 1'b0;
    repeat (24) step();
    check_eq("mid_i_valid", 32'(i_addr_valid), 32'd1);
    check_eq("mid_i_addr", 32'(i_addr), 32'd8);
    aclr = 1'b1;
    step();
    aclr = 1'b0;
    check_eq("aclr_valids", 32'({w_addr_valid, i_addr_valid, o_addr_valid}), 32'd0);
    check_eq("aclr_ptrs", 32'(w_addr | i_addr | o_addr | o_wr_addr), 32'd0);
    check_eq("aclr_busy", 32'(busy), 32'd0);
    check_eq("aclr_tile", 32'(tile_idx), 32'd0);
    check_eq("aclr_done", 32'(done), 32'd0);
    step();
    check_eq("aclr_no_done", 32'(done), 32'd0);

    run_job(1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
